// File: rtl/qspi_slave_wb_bridge.sv
// qspi_slave_wb_bridge: quad-SPI slave that turns host frames into 32-bit Wishbone master accesses
//   i_sys_clk, i_rst      : system clock, synchronous active-high reset
//   i_sclk, i_ssn, i_sdin : async QSPI pins (mode 0), oversampled through 2-FF synchronisers
//   o_sdout, o_sdout_oen  : read-data nibble and pad direction (0 = drive)
//   o_spi_if_st, o_bitcnt : FSM state code and bits moved in the current phase
//   o_sck_toggle, o_inst_trg, o_addr_trg, o_spi_st_trans, o_spi_trig : 1-cycle debug strobes
//   o_wbm_* / i_wbm_*     : Wishbone master (single outstanding cycle, sel always 4'hF)
module qspi_slave_wb_bridge #(
    parameter logic [7:0] CMD_WR    = 8'h02,
    parameter logic [7:0] CMD_RD    = 8'h0B,
    parameter int         DUMMY_CYC = 8
) (
    input  logic        i_sys_clk,
    input  logic        i_rst,
    input  logic        i_sclk,
    input  logic        i_ssn,
    input  logic [3:0]  i_sdin,
    output logic [3:0]  o_sdout,
    output logic        o_sdout_oen,
    output logic [2:0]  o_spi_if_st,
    output logic        o_sck_toggle,
    output logic [5:0]  o_bitcnt,
    output logic        o_inst_trg,
    output logic        o_addr_trg,
    output logic        o_spi_st_trans,
    output logic        o_spi_trig,
    output logic        o_wbm_cyc,
    output logic        o_wbm_stb,
    output logic [31:0] o_wbm_adr,
    output logic        o_wbm_we,
    output logic [31:0] o_wbm_dat,
    output logic [3:0]  o_wbm_sel,
    input  logic [31:0] i_wbm_dat,
    input  logic        i_wbm_ack,
    input  logic        i_wbm_err
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_CMD = 3'd1, S_ADDR = 3'd2, S_DUMMY = 3'd3,
        S_WDATA = 3'd4, S_RDATA = 3'd5, S_IGNORE = 3'd6
    } state_t;
    localparam logic [5:0] DUMMY_LAST = 6'(4 * (DUMMY_CYC - 1));
    state_t      r_state, w_next;
    logic [1:0]  r_sclk_s, r_ssn_s;
    logic [3:0]  r_sdin_s0, r_sdin_s1;
    logic        r_sclk_d, r_ssn_d;
    logic [5:0]  r_bitcnt;
    logic [31:0] r_sh, r_rsh, r_addr, r_rdata;
    logic        r_is_rd, r_rd_go, r_rvalid, r_discard;
    logic [3:0]  r_sdout;
    logic        r_oen, r_sck_toggle, r_inst_trg, r_addr_trg, r_st_trans, r_spi_trig;
    logic        r_cyc, r_we;
    logic [31:0] r_adr, r_dat;
    logic [3:0]  r_sel;
    logic        w_sclk, w_ssn, w_rise, w_fall, w_ssn_fall, w_last, w_ack;
    logic        w_wr_word, w_load, w_wr_launch, w_rd_launch, w_pf_launch, w_launch;
    logic [5:0]  w_last_tgt;
    logic [31:0] w_sh_next, w_word;
    assign w_sclk      = r_sclk_s[1];
    assign w_ssn       = r_ssn_s[1];
    assign w_rise      = w_sclk & ~r_sclk_d;
    assign w_fall      = ~w_sclk & r_sclk_d;
    assign w_ssn_fall  = ~w_ssn & r_ssn_d;
    assign w_sh_next   = {r_sh[27:0], r_sdin_s1};
    assign w_last_tgt  = (r_state == S_CMD) ? 6'd4 : (r_state == S_DUMMY) ? DUMMY_LAST : 6'd28;
    assign w_last      = w_rise & ~w_ssn & (r_bitcnt == w_last_tgt);
    assign w_ack       = r_cyc & (i_wbm_ack | i_wbm_err);
    assign w_wr_word   = (r_state == S_WDATA) & w_last;
    // A word is loaded into the output shifter on the fall that starts its first nibble
    assign w_load      = (r_state == S_RDATA) & w_fall & ~w_ssn & (r_bitcnt == 6'd0);
    assign w_wr_launch = w_wr_word & ~r_cyc;
    assign w_rd_launch = r_rd_go & ~r_cyc & ~w_ssn;
    assign w_pf_launch = w_load & ~r_cyc;
    assign w_launch    = w_wr_launch | w_rd_launch | w_pf_launch;
    // Data that never arrived in time is shifted out as all ones
    assign w_word      = r_rvalid ? r_rdata : 32'hFFFF_FFFF;
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_ssn_fall ? S_CMD : S_IDLE;
            S_CMD:   if (w_last) w_next = (w_sh_next[7:0] == CMD_WR || w_sh_next[7:0] == CMD_RD) ? S_ADDR : S_IGNORE;
            S_ADDR:  if (w_last) w_next = r_is_rd ? S_DUMMY : S_WDATA;
            S_DUMMY: if (w_last) w_next = S_RDATA;
            default: w_next = r_state;
        endcase
        if (r_state != S_IDLE && w_ssn) w_next = S_IDLE;
    end
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_sclk_s <= 2'b00;  r_sclk_d <= 1'b0;
            r_ssn_s <= 2'b11;   r_ssn_d <= 1'b1;
            r_sdin_s0 <= 4'h0;  r_sdin_s1 <= 4'h0;
            r_bitcnt <= 6'd0;   r_sh <= 32'h0;    r_rsh <= 32'h0;
            r_addr <= 32'h0;    r_rdata <= 32'h0; r_is_rd <= 1'b0;
            r_rd_go <= 1'b0;    r_rvalid <= 1'b0; r_discard <= 1'b0;
            r_sdout <= 4'h0;    r_oen <= 1'b1;    r_sck_toggle <= 1'b0;
            r_inst_trg <= 1'b0; r_addr_trg <= 1'b0;
            r_st_trans <= 1'b0; r_spi_trig <= 1'b0;
            r_cyc <= 1'b0;      r_we <= 1'b0;     r_adr <= 32'h0;
            r_dat <= 32'h0;     r_sel <= 4'h0;
        end else begin
            r_sclk_s <= {r_sclk_s[0], i_sclk};
            r_sclk_d <= w_sclk;
            r_ssn_s <= {r_ssn_s[0], i_ssn};
            r_ssn_d <= w_ssn;
            r_sdin_s0 <= i_sdin;
            r_sdin_s1 <= r_sdin_s0;
            r_sck_toggle <= w_rise;
            r_st_trans <= (w_next != r_state);
            r_inst_trg <= (r_state == S_CMD) & w_last;
            r_addr_trg <= (r_state == S_ADDR) & w_last;
            r_rd_go <= (r_state == S_ADDR) & w_last & r_is_rd;
            r_oen <= (w_next != S_RDATA);
            r_spi_trig <= w_launch;
            if (w_next != r_state) r_bitcnt <= 6'd0;
            else if (w_rise && r_state != S_IDLE && r_state != S_IGNORE) r_bitcnt <= w_last ? 6'd0 : r_bitcnt + 6'd4;
            if (w_rise) r_sh <= w_sh_next;
            if ((r_state == S_CMD) && w_last) r_is_rd <= (w_sh_next[7:0] == CMD_RD);
            if ((r_state == S_ADDR) && w_last) r_addr <= w_sh_next;
            else if (w_wr_word || w_load) r_addr <= r_addr + 32'd4;
            if (w_next != S_RDATA) r_sdout <= 4'h0;
            else if (w_load) begin
                r_sdout <= w_word[31:28];
                r_rsh <= {w_word[27:0], 4'h0};
            end else if ((r_state == S_RDATA) && w_fall) begin
                r_sdout <= r_rsh[31:28];
                r_rsh <= {r_rsh[27:0], 4'h0};
            end
            // Read data is kept only if the frame is still open and the word has not been consumed yet
            if (w_load || r_state == S_IDLE) r_rvalid <= 1'b0;
            else if (w_ack && !r_we && !r_discard && !w_ssn) begin
                r_rvalid <= 1'b1;
                r_rdata <= i_wbm_err ? 32'h0 : i_wbm_dat;
            end
            if (w_launch) r_discard <= 1'b0;
            else if (r_cyc && (w_ssn || w_load)) r_discard <= 1'b1;
            if (w_ack) begin
                r_cyc <= 1'b0;
                r_sel <= 4'h0;
            end else if (w_launch) begin
                r_cyc <= 1'b1;
                r_sel <= 4'hF;
                r_we <= w_wr_launch;
                r_adr <= w_pf_launch ? r_addr + 32'd4 : r_addr;
                if (w_wr_launch) r_dat <= w_sh_next;
            end
        end
    end
    assign o_sdout        = r_sdout;
    assign o_sdout_oen    = r_oen;
    assign o_spi_if_st    = r_state;
    assign o_sck_toggle   = r_sck_toggle;
    assign o_bitcnt       = r_bitcnt;
    assign o_inst_trg     = r_inst_trg;
    assign o_addr_trg     = r_addr_trg;
    assign o_spi_st_trans = r_st_trans;
    assign o_spi_trig     = r_spi_trig;
    assign o_wbm_cyc      = r_cyc;
    assign o_wbm_stb      = r_cyc;
    assign o_wbm_adr      = r_adr;
    assign o_wbm_we       = r_we;
    assign o_wbm_dat      = r_dat;
    assign o_wbm_sel      = r_sel;
endmodule

// File: tb/tb_qspi_slave_wb_bridge.sv
// tb_qspi_slave_wb_bridge: directed and randomized frames against a memory-level reference model
module tb_qspi_slave_wb_bridge;
    localparam int H = 6;
    logic        clk = 1'b0, rst = 1'b1, sclk = 1'b0, ssn = 1'b1;
    logic [3:0]  sdin = 4'h0;
    logic [3:0]  o_sdout;
    logic        o_sdout_oen, o_sck_toggle, o_inst_trg, o_addr_trg, o_spi_st_trans, o_spi_trig;
    logic [2:0]  o_spi_if_st;
    logic [5:0]  o_bitcnt;
    logic        o_wbm_cyc, o_wbm_stb, o_wbm_we;
    logic [31:0] o_wbm_adr, o_wbm_dat;
    logic [3:0]  o_wbm_sel;
    logic [31:0] wb_dat = 32'h0;
    logic        wb_ack = 1'b0, wb_err = 1'b0;
    qspi_slave_wb_bridge dut (
        .i_sys_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_ssn(ssn), .i_sdin(sdin),
        .o_sdout(o_sdout), .o_sdout_oen(o_sdout_oen), .o_spi_if_st(o_spi_if_st),
        .o_sck_toggle(o_sck_toggle), .o_bitcnt(o_bitcnt), .o_inst_trg(o_inst_trg),
        .o_addr_trg(o_addr_trg), .o_spi_st_trans(o_spi_st_trans), .o_spi_trig(o_spi_trig),
        .o_wbm_cyc(o_wbm_cyc), .o_wbm_stb(o_wbm_stb), .o_wbm_adr(o_wbm_adr),
        .o_wbm_we(o_wbm_we), .o_wbm_dat(o_wbm_dat), .o_wbm_sel(o_wbm_sel),
        .i_wbm_dat(wb_dat), .i_wbm_ack(wb_ack), .i_wbm_err(wb_err)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } txn_t;
    txn_t q[$];
    logic [31:0] mem [logic [31:0]];
    bit   hold = 1'b0, err_mode = 1'b0;
    int   checks = 0, errors = 0;
    int   n_inst = 0, n_addr = 0, n_trig_bad = 0, wcnt = 0;
    logic prev_cyc = 1'b0;
    // Bus monitor: logs each new cycle and checks spi_trig coincides with cyc rising
    always @(negedge clk) begin
        prev_cyc <= o_wbm_cyc;
        if (o_inst_trg) n_inst <= n_inst + 1;
        if (o_addr_trg) n_addr <= n_addr + 1;
        if (o_spi_trig !== (o_wbm_cyc & ~prev_cyc)) n_trig_bad <= n_trig_bad + 1;
        if (o_wbm_cyc && !prev_cyc) q.push_back({o_wbm_we, o_wbm_adr, o_wbm_dat, o_wbm_sel});
    end
    // Wishbone slave: fixed latency, optional hold-off and error response
    always @(posedge clk) begin
        if (wb_ack || wb_err) begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            wcnt <= 0;
        end else if (!o_wbm_cyc) wcnt <= 0;
        else if (!hold) begin
            if (wcnt >= 2) begin
                if (err_mode) wb_err <= 1'b1;
                else wb_ack <= 1'b1;
                wb_dat <= mem.exists(o_wbm_adr) ? mem[o_wbm_adr] : 32'hDEAD_BEEF;
            end else wcnt <= wcnt + 1;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic sck(input logic [3:0] n, output logic [3:0] s, output logic oe);
        sdin = n;
        tick(H);
        s = o_sdout;
        oe = o_sdout_oen;
        sclk = 1'b1;
        tick(H);
        sclk = 1'b0;
    endtask
    task automatic send(input logic [31:0] v, input int nn, inout int bad_oe);
        logic [3:0] s;
        logic oe;
        for (int i = 0; i < nn; i++) begin
            sck(v[4*(nn-1-i) +: 4], s, oe);
            if (oe !== 1'b1) bad_oe++;
        end
    endtask
    task automatic begin_frame();
        ssn = 1'b0;
        tick(H);
    endtask
    task automatic end_frame();
        tick(H);
        ssn = 1'b1;
        sdin = 4'h0;
        tick(2 * H);
    endtask
    task automatic write_frame(input logic [31:0] a, input logic [31:0] d0, d1, d2, input int n);
        int b = 0;
        begin_frame();
        send(32'h02, 2, b);
        send(a, 8, b);
        send(d0, 8, b);
        if (n > 1) send(d1, 8, b);
        if (n > 2) send(d2, 8, b);
        end_frame();
    endtask
    // Returns the shifted-out words (first word in the high half) and the count of oen violations
    task automatic read_frame(input logic [31:0] a, input int nw, output logic [63:0] got, output int bad_oe);
        logic [3:0] s;
        logic oe;
        bad_oe = 0;
        got = 64'h0;
        begin_frame();
        send(32'h0B, 2, bad_oe);
        send(a, 8, bad_oe);
        send(32'h0, 8, bad_oe);
        for (int i = 0; i < 8 * nw; i++) begin
            sck(4'h0, s, oe);
            got = {got[59:0], s};
            if (oe !== 1'b0) bad_oe++;
        end
        end_frame();
    endtask
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && o_wbm_cyc; i++) tick(1);
        chk(tag, {31'h0, o_wbm_cyc}, 32'h0);
    endtask
    initial begin
        logic [63:0] got;
        logic [31:0] a, d0, d1, d2;
        int bad, i0, a0;
        txn_t t;
        tick(4);
        rst = 1'b0;
        tick(2);
        chk("rst_state", {29'h0, o_spi_if_st}, 32'd0);
        chk("rst_oen", {31'h0, o_sdout_oen}, 32'd1);
        chk("rst_sdout", {28'h0, o_sdout}, 32'd0);
        chk("rst_bitcnt", {26'h0, o_bitcnt}, 32'd0);
        chk("rst_cyc", {30'h0, o_wbm_cyc, o_wbm_stb}, 32'd0);
        chk("rst_adr", o_wbm_adr, 32'h0);
        chk("rst_dat", o_wbm_dat, 32'h0);
        chk("rst_sel_we", {27'h0, o_wbm_sel, o_wbm_we}, 32'h0);
        // single write
        i0 = n_inst; a0 = n_addr; q.delete();
        write_frame(32'h10, 32'h1234_5678, 32'h0, 32'h0, 1);
        wait_idle("t1_idle");
        chk("t1_ntxn", q.size(), 32'd1);
        if (q.size() > 0) begin
            t = q.pop_front();
            chk("t1_adr", t.adr, 32'h10);
            chk("t1_dat", t.dat, 32'h1234_5678);
            chk("t1_we_sel", {27'h0, t.we, t.sel}, 32'h1F);
        end
        chk("t1_inst_trg", n_inst - i0, 32'd1);
        chk("t1_addr_trg", n_addr - a0, 32'd1);
        // single read
        mem[32'h10] = 32'hCAFE_F00D;
        mem[32'h14] = $urandom;
        q.delete();
        read_frame(32'h10, 1, got, bad);
        chk("t2_data", got[31:0], 32'hCAFE_F00D);
        chk("t2_oen", bad, 32'd0);
        chk("t2_oen_after", {31'h0, o_sdout_oen}, 32'd1);
        chk("t2_state_after", {29'h0, o_spi_if_st}, 32'd0);
        if (q.size() > 0) begin
            t = q.pop_front();
            chk("t2_rd_adr_we", {t.adr[30:0], t.we}, {31'h10, 1'b0});
        end else chk("t2_rd_txn", 32'd0, 32'd1);
        wait_idle("t2_idle");
        // burst write of three random words
        d0 = $urandom; d1 = $urandom; d2 = $urandom;
        q.delete();
        write_frame(32'h100, d0, d1, d2, 3);
        wait_idle("t3_idle");
        chk("t3_ntxn", q.size(), 32'd3);
        for (int i = 0; i < 3 && q.size() > 0; i++) begin
            t = q.pop_front();
            chk("t3_adr", t.adr, 32'h100 + 32'(4 * i));
            chk("t3_dat", t.dat, (i == 0) ? d0 : (i == 1) ? d1 : d2);
        end
        // randomized two-word read bursts exercising the prefetch
        for (int k = 0; k < 3; k++) begin
            a = $urandom & 32'h0000_FFFC;
            mem[a] = $urandom;
            mem[a + 32'd4] = $urandom;
            read_frame(a, 2, got, bad);
            chk("t4_word0", got[63:32], mem[a]);
            chk("t4_word1", got[31:0], mem[a + 32'd4]);
            chk("t4_oen", bad, 32'd0);
            wait_idle("t4_idle");
        end
        // ack withheld past the dummy phase, then recovery
        mem[32'h200] = $urandom;
        hold = 1'b1;
        read_frame(32'h200, 1, got, bad);
        chk("t5_ffff", got[31:0], 32'hFFFF_FFFF);
        hold = 1'b0;
        wait_idle("t5_idle");
        read_frame(32'h200, 1, got, bad);
        chk("t5_recover", got[31:0], mem[32'h200]);
        wait_idle("t5_idle2");
        // error response reads as zero
        err_mode = 1'b1;
        read_frame(32'h200, 1, got, bad);
        chk("t6_err_zero", got[31:0], 32'h0);
        err_mode = 1'b0;
        wait_idle("t6_idle");
        // unknown command
        q.delete();
        bad = 0;
        begin_frame();
        send(32'h9F, 2, bad);
        send(32'h12, 2, bad);
        chk("t7_ignore", {29'h0, o_spi_if_st}, 32'd6);
        chk("t7_oen", bad, 32'd0);
        end_frame();
        chk("t7_idle", {29'h0, o_spi_if_st}, 32'd0);
        chk("t7_no_txn", q.size(), 32'd0);
        // ssn raised mid-address
        begin_frame();
        send(32'h02, 2, bad);
        send(32'h0AB, 3, bad);
        chk("t8_addr_state", {29'h0, o_spi_if_st}, 32'd2);
        chk("t8_addr_bitcnt", {26'h0, o_bitcnt}, 32'd12);
        ssn = 1'b1;
        tick(5);
        chk("t8_abort_state", {29'h0, o_spi_if_st}, 32'd0);
        chk("t8_abort_bitcnt", {26'h0, o_bitcnt}, 32'd0);
        chk("t8_abort_oen", {31'h0, o_sdout_oen}, 32'd1);
        // reset during a pending write
        hold = 1'b1;
        q.delete();
        write_frame(32'h300, $urandom, 32'h0, 32'h0, 1);
        chk("t9_pending", {30'h0, o_wbm_cyc, o_wbm_stb}, 32'd3);
        chk("t9_pending_adr", o_wbm_adr, 32'h300);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("t9_cyc", {30'h0, o_wbm_cyc, o_wbm_stb}, 32'd0);
        chk("t9_adr", o_wbm_adr, 32'h0);
        chk("t9_dat", o_wbm_dat, 32'h0);
        chk("t9_sel_we", {27'h0, o_wbm_sel, o_wbm_we}, 32'h0);
        chk("t9_state", {29'h0, o_spi_if_st}, 32'd0);
        chk("t9_bitcnt", {26'h0, o_bitcnt}, 32'd0);
        hold = 1'b0;
        tick(10);
        chk("spi_trig_align", n_trig_bad, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
